// File: rtl/strobe_capture_reg.sv
// rtl/strobe_capture_reg.sv - strobe-qualified capture register with event counter
//
// Captures a WIDTH-bit bus under control of an asynchronous strobe. Both the
// strobe and the data pass through equal-depth synchroniser chains so that
// captured data stays aligned with the strobe level it accompanied.
//
// Ports:
//   clk        system clock, rising-edge
//   rst_n      asynchronous active-low reset
//   strobe     asynchronous capture strobe
//   d          asynchronous data, sampled alongside strobe
//   mode       00 level-transparent, 01 rising, 10 falling, 11 both edges
//   clr        synchronous clear of q, cap_count, ovf (wins over an event)
//   q          captured data
//   cap_pulse  one-cycle pulse per capture event
//   cap_count  saturating capture event count
//   ovf        sticky: event seen while cap_count at maximum
module strobe_capture_reg #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             cap_pulse,
  output logic [CNT_W-1:0] cap_count,
  output logic             ovf
);

  localparam logic [1:0] MODE_LEVEL   = 2'b00;
  localparam logic [1:0] MODE_RISING  = 2'b01;
  localparam logic [1:0] MODE_FALLING = 2'b10;
  localparam logic [1:0] MODE_BOTH    = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] s_sync;
  logic [WIDTH-1:0]       d_sync [SYNC_STAGES];
  logic                   s_prev;

  logic             s_s;
  logic [WIDTH-1:0] d_s;
  logic             rise;
  logic             fall;
  logic             evt;
  logic             load;

  // Synchronisers and edge-history flop. Never touched by clr so that a
  // clear cannot fabricate or swallow a later transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        d_sync[i] <= '0;
      end
      s_prev <= 1'b0;
    end else begin
      s_sync    <= {s_sync[SYNC_STAGES-2:0], strobe};
      d_sync[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        d_sync[i] <= d_sync[i-1];
      end
      s_prev <= s_s;
    end
  end

  assign s_s  = s_sync[SYNC_STAGES-1];
  assign d_s  = d_sync[SYNC_STAGES-1];
  assign rise = s_s & ~s_prev;
  assign fall = ~s_s & s_prev;

  // Event qualification. Level mode counts the rising edge as its event even
  // though the register itself is transparent for the whole high phase.
  always_comb begin
    evt  = 1'b0;
    load = 1'b0;
    case (mode)
      MODE_LEVEL: begin
        evt  = rise;
        load = s_s;
      end
      MODE_RISING: begin
        evt  = rise;
        load = rise;
      end
      MODE_FALLING: begin
        evt  = fall;
        load = fall;
      end
      MODE_BOTH: begin
        evt  = rise | fall;
        load = rise | fall;
      end
      default: begin
        evt  = 1'b0;
        load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      cap_pulse <= 1'b0;
      cap_count <= '0;
      ovf       <= 1'b0;
    end else if (clr) begin
      // A coincident event is deliberately dropped.
      q         <= '0;
      cap_pulse <= 1'b0;
      cap_count <= '0;
      ovf       <= 1'b0;
    end else begin
      cap_pulse <= evt;
      if (load) begin
        q <= d_s;
      end
      if (evt) begin
        if (cap_count != CNT_MAX) begin
          cap_count <= cap_count + 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_strobe_capture_reg.sv
// tb/tb_strobe_capture_reg.sv - scoreboard bench for strobe_capture_reg
module tb_strobe_capture_reg;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          strobe = 1'b0;
  logic [W-1:0]  d = '0;
  logic [1:0]    mode = 2'b00;
  logic          clr = 1'b0;
  logic [W-1:0]  q;
  logic          cap_pulse;
  logic [CW-1:0] cap_count;
  logic          ovf;

  int errors = 0;
  int checks = 0;

  strobe_capture_reg #(.WIDTH(W), .SYNC_STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .strobe(strobe), .d(d), .mode(mode), .clr(clr),
    .q(q), .cap_pulse(cap_pulse), .cap_count(cap_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of what each clock edge since reset sampled.
  // A level first sampled at edge E0 becomes visible at edge E0+S, so the
  // update at edge n compares samples n-S (new) and n-S-1 (old).
  bit           s_hist[$];
  logic [W-1:0] d_hist[$];
  logic [W-1:0] m_q = '0;
  int           m_cnt = 0;
  bit           m_ovf = 0;
  bit           m_pulse = 0;
  logic [W+CW:0] sb[$];

  function automatic bit hs(int i);
    return (i < 0) ? 1'b0 : s_hist[i];
  endfunction

  function automatic logic [W-1:0] hd(int i);
    return (i < 0) ? '0 : d_hist[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_hist.delete();
      d_hist.delete();
      sb.delete();
      m_q = '0; m_cnt = 0; m_ovf = 0; m_pulse = 0;
    end else begin
      int n;
      bit lvl, old, ev;
      s_hist.push_back(strobe);
      d_hist.push_back(d);
      n   = s_hist.size() - 1;
      lvl = hs(n - S);
      old = hs(n - S - 1);
      case (mode)
        2'b10:   ev = old && !lvl;
        2'b11:   ev = old != lvl;
        default: ev = lvl && !old;
      endcase
      if (clr) begin
        m_q = '0; m_cnt = 0; m_ovf = 0; m_pulse = 0;
      end else begin
        m_pulse = ev;
        if ((mode == 2'b00) ? lvl : ev) m_q = hd(n - S);
        if (ev) begin
          if (m_cnt == CMAX) m_ovf = 1;
          else m_cnt = m_cnt + 1;
          sb.push_back({m_q, m_cnt[CW-1:0], m_ovf});
        end
      end
    end
  end

  // Monitor: per-cycle state compare plus scoreboard pop on every capture.
  int pulses_seen = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("q", q, m_q);
      chk("cap_count", cap_count, m_cnt);
      chk("ovf", ovf, m_ovf);
      chk("cap_pulse", cap_pulse, m_pulse);
      if (cap_pulse === 1'b1) begin
        pulses_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_capture", 1, 0);
        end else begin
          logic [W+CW:0] e;
          e = sb.pop_front();
          chk("sb_capture", {q, cap_count, ovf}, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  initial begin
    int p0;
    // Reset state while held.
    step(2);
    #1;
    chk("rst_q", q, 0);
    chk("rst_pulse", cap_pulse, 0);
    chk("rst_cnt", cap_count, 0);
    chk("rst_ovf", ovf, 0);
    step(1);
    rst_n = 1'b1;
    step(3);

    // Rising mode: capture two edges after the strobe level reaches the chain.
    mode = 2'b01; d = 8'hA5; strobe = 1'b1;
    step(2);
    chk("rise_early_pulse", cap_pulse, 0);
    step(1);
    chk("rise_q", q, 8'hA5);
    chk("rise_pulse", cap_pulse, 1);
    chk("rise_cnt", cap_count, 1);
    step(7);
    strobe = 1'b0;
    step(5);
    chk("rise_fall_nochg", cap_count, 1);

    // Falling mode: data changed while high, captured at the fall.
    do_clr();
    mode = 2'b10; d = 8'h3C; strobe = 1'b1;
    step(3);
    d = 8'h77;
    step(2);
    strobe = 1'b0;
    step(5);
    chk("fall_q", q, 8'h77);
    chk("fall_cnt", cap_count, 1);

    // Level mode: transparent while high, holds after.
    do_clr();
    mode = 2'b00;
    strobe = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d = i[W-1:0];
      step(1);
    end
    strobe = 1'b0; d = 8'hEE;
    step(5);
    chk("level_hold_q", q, 8'h04);
    chk("level_cnt", cap_count, 1);

    // Both edges: saturation and overflow, then clear.
    do_clr();
    mode = 2'b11;
    for (int i = 0; i < 20; i++) begin
      strobe = ~strobe; d = $urandom;
      step(2);
    end
    step(4);
    chk("sat_cnt", cap_count, CMAX);
    chk("sat_ovf", ovf, 1);
    do_clr();
    chk("clr_q", q, 0);
    chk("clr_cnt", cap_count, 0);
    chk("clr_ovf", ovf, 0);

    // Back-to-back events: pulse stays high.
    p0 = pulses_seen;
    for (int i = 0; i < 6; i++) begin
      strobe = ~strobe;
      step(1);
    end
    step(4);
    chk("b2b_pulses", pulses_seen - p0, 6);
    strobe = 1'b0;
    step(4);

    // Clear coincident with an event: event lost.
    do_clr();
    mode = 2'b01; d = 8'h5A; strobe = 1'b1;
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_evt_q", q, 0);
    chk("clr_evt_pulse", cap_pulse, 0);
    chk("clr_evt_cnt", cap_count, 0);
    strobe = 1'b0;
    step(5);

    // Reset mid-transfer, release with strobe still high.
    strobe = 1'b1; d = 8'hC3;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("amid_q", q, 0);
    chk("amid_pulse", cap_pulse, 0);
    chk("amid_cnt", cap_count, 0);
    step(2);
    p0 = pulses_seen;
    rst_n = 1'b1;
    step(2);
    chk("rel_no_early", pulses_seen - p0, 0);
    step(1);
    chk("rel_pulse", cap_pulse, 1);
    step(5);
    chk("rel_one_capture", pulses_seen - p0, 1);
    chk("rel_cnt", cap_count, 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) strobe = ~strobe;
      d = $urandom;
      if ($urandom_range(0, 19) == 0) mode = $urandom;
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step(1);
    end
    clr = 1'b0;
    step(6);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/strobe_capture_reg.md
# strobe_capture_reg

Parametrised capture register bank. It is the synchronous successor to the team's latch and flip-flop demonstration elements. A WIDTH-bit data bus is captured under control of an asynchronous strobe input, which is first synchronised into the system clock domain. The capture rule is programmable: level-transparent, rising edge, falling edge, or both edges. A saturating event counter and an overflow flag are included for board-level debug (switch and LED driven) and for reuse as a generic sampled input port.

## Interface

Parameters:
- WIDTH, 8, data and capture register width (≥1)
- SYNC_STAGES, 2, synchroniser depth applied to both strobe and data (≥2)
- CNT_W, 8, capture counter width (≥1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- strobe  input  1  asynchronous capture strobe (the "clock" of the old elements)
- d  input  WIDTH  asynchronous data, sampled alongside strobe
- mode  input  2  00 level, 01 rising, 10 falling, 11 both edges
- clr  input  1  synchronous clear of q, cap_count, ovf
- q  output  WIDTH  captured data
- cap_pulse  output  1  one-cycle pulse per capture event
- cap_count  output  CNT_W  saturating count of capture events
- ovf  output  1  sticky, event seen while cap_count at maximum

## Operation

- strobe and d each pass through a SYNC_STAGES-deep flop chain, giving s_s and d_s. Data stays aligned with its strobe.
- s_prev is s_s delayed by one cycle. It is tracked in every mode.
- rise = s_s & ~s_prev; fall = ~s_s & s_prev.
- event per mode:
  - 00: rise
  - 01: rise
  - 10: fall
  - 11: rise | fall
- q update per mode:
  - Mode 00: q <= d_s on every cycle where s_s = 1 (transparent while high). q holds while s_s = 0.
  - Modes 01/10/11: q <= d_s only on cycles where event = 1. q holds otherwise.
- On an event:
  - cap_pulse <= 1 for exactly one cycle.
  - If cap_count < 2^CNT_W−1, cap_count increments.
  - Otherwise cap_count holds and ovf <= 1.
- clr = 1:
  - q, cap_count and ovf go to 0 at the next edge. cap_pulse goes to 0 for that cycle.
  - clr wins over a simultaneous event, and that event is lost.
  - The synchroniser chain and s_prev are unaffected.
- mode is sampled each cycle and is used combinationally with the current s_s/s_prev.
  - A mode change never creates an event by itself; only an actual s_s transition does.
  - After a change, the new mode applies from the next edge.
- ovf stays set until clr or reset.

## Timing

- Reset (rst_n = 0) forces all synchroniser flops, s_prev, q, cap_pulse, cap_count and ovf to 0 immediately.
- Latency: let E0 be the clock edge that first samples a new strobe level. Then q and cap_pulse reflect the capture after edge E0+SYNC_STAGES, and cap_count updates at the same edge.
- The captured value is the d value sampled at edge E0.
- d must be stable one cycle around the strobe transition.
- Minimum strobe high or low time to register as a level: 1 clk period. Shorter glitches may be missed, and missed glitches produce no event.
- Strobe held high through reset release is a rising transition: with mode 01, it yields one capture SYNC_STAGES cycles after release.
- Back-to-back events on consecutive cycles (mode 11, strobe toggling every cycle) each produce a capture; cap_pulse stays high continuously.
- Reset asserted mid-operation aborts any in-flight transition. No capture is produced for it after release unless the strobe level is still 1 (see above).

## Test plan

Settings for all scenarios: WIDTH=8, SYNC_STAGES=2, CNT_W=4.

- Reset, then mode=01, d=0xA5, strobe rises at edge 10 → q=0xA5 and cap_pulse=1 after edge 12 only, cap_count=1. Strobe falls at edge 20 → no change.
- mode=10, d=0x3C, strobe pulse high over edges 5–9 with d changed to 0x77 at edge 8 → a single capture after the falling edge reaches s_s, q=0x77, cap_count=1.
- mode=00, strobe high for edges 4–7, d stepping 0x01,0x02,0x03,0x04 → q follows each value with 2-cycle lag. Strobe low → q holds 0x04. cap_pulse fires once; count=1.
- mode=11, strobe toggles every 2 cycles for 20 events → cap_count saturates at 15 and ovf=1 after the 16th event. clr pulse → q=0, cap_count=0, ovf=0 next cycle.
- clr asserted on the same cycle as an event → q=0, cap_pulse=0, cap_count=0.
- rst_n dropped mid-transfer (1 cycle after strobe rise) → all outputs 0 asynchronously. Release with strobe=1, mode=01 → exactly one capture 2 cycles after release.
